writeback_stage: RTL and testbench

- Final pipeline stage of the 8-bit core. Consumes the execute stage's result, flags and destination fields, and commits them to architectural state.
- Commits go to register-file write port, data-memory write port, flag register and compare bit.
- Sequences the two-cycle writeback for MUL/DIV 16-bit results. Latches HALT.
- All write strobes are registered, one cycle after acceptance.

---
 rtl/core_pkg.sv | 69 ++++++
 rtl/writeback_stage_if.sv | 25 ++
 rtl/writeback_stage.sv | 137 +++++++++++++
 tb/tb_writeback_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: widths, opcodes, flag positions, writeback states
// and opcode classification helpers reused by decode, execute and writeback.
package core_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned MEM_AW = 4;
  localparam int unsigned OPC_W  = 5;

  localparam logic [OPC_W-1:0] OP_MOV   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00001;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_MUL   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_DIV   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_INC   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_DEC   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b01000;
  localparam logic [OPC_W-1:0] OP_NOT   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_LOAD  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_STORE = 5'b01100;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'b01101;
  localparam logic [OPC_W-1:0] OP_BR0   = 5'b01110;
  localparam logic [OPC_W-1:0] OP_SHF0  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_SHF5  = 5'b10101;
  localparam logic [OPC_W-1:0] OP_BR1   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_BR2   = 5'b10111;
  localparam logic [OPC_W-1:0] OP_BR3   = 5'b11000;
  localparam logic [OPC_W-1:0] OP_CMP   = 5'b11001;
  localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

  // Bit positions inside the committed {zero,carry,ac,parity} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_A = 1;
  localparam int unsigned FLAG_P = 0;

  typedef enum logic [1:0] {
    StAccept  = 2'd0,
    StWriteHi = 2'd1,
    StHalted  = 2'd2
  } wb_state_e;

  function automatic logic is_shift(input logic [OPC_W-1:0] op);
    return (op >= OP_SHF0) && (op <= OP_SHF5);
  endfunction

  function automatic logic is_wide(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic writes_reg(input logic [OPC_W-1:0] op);
    case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_NOT, OP_XOR,
      OP_LOAD: return 1'b1;
      default: return is_shift(op);
    endcase
  endfunction

  function automatic logic writes_flags(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC, OP_AND, OP_OR, OP_NOT, OP_XOR,
      OP_CMP: return 1'b1;
      default: return is_shift(op);
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handshake bundle: valid/ready plus the instruction's result fields.
interface writeback_stage_if;
  import core_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OPC_W-1:0]    opcode;
  logic [REG_AW-1:0]   rd;
  logic [MEM_AW-1:0]   mem_addr;
  logic [2*DATA_W-1:0] result;
  logic                zero_in;
  logic                carry_in;
  logic                ac_in;
  logic                parity_in;

  modport master (
    output in_valid, opcode, rd, mem_addr, result, zero_in, carry_in, ac_in, parity_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, opcode, rd, mem_addr, result, zero_in, carry_in, ac_in, parity_in,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits register/memory writes, flags and compare bit one cycle after
// acceptance, sequences the second register write of MUL/DIV and latches HALT.
module writeback_stage
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  writeback_stage_if.slave    ex,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                dm_we,
  output logic [MEM_AW-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  output logic [3:0]          flags_q,
  output logic                cmp_q,
  output logic                halted,
  output logic [15:0]         retire_cnt
);

  wb_state_e           state_q, state_d;
  logic                rf_we_q, rf_we_d, dm_we_q, dm_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d, hi_addr_q, hi_addr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d, hi_data_q, hi_data_d;
  logic [MEM_AW-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [3:0]          flags_d, flags_r;
  logic                cmp_d, cmp_r, halted_d, halted_r;
  logic [15:0]         retire_d, retire_r;
  logic                accept;

  assign ex.in_ready = (state_q == StAccept) && !reset;
  assign accept      = ex.in_valid && ex.in_ready;

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    dm_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    hi_addr_d  = hi_addr_q;
    hi_data_d  = hi_data_q;
    flags_d    = flags_r;
    cmp_d      = cmp_r;
    halted_d   = halted_r;
    retire_d   = retire_r;

    unique case (state_q)
      StAccept: begin
        if (accept) begin
          retire_d = retire_r + 16'd1;
          if (writes_reg(ex.opcode) || is_wide(ex.opcode)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex.rd;
            rf_wdata_d = ex.result[DATA_W-1:0];
          end
          if (is_wide(ex.opcode)) begin
            // High byte lands in the next register, wrapping r7 -> r0.
            hi_addr_d = ex.rd + REG_AW'(1);
            hi_data_d = ex.result[2*DATA_W-1:DATA_W];
            state_d   = StWriteHi;
          end
          if (ex.opcode == OP_STORE) begin
            dm_we_d    = 1'b1;
            dm_addr_d  = ex.mem_addr;
            dm_wdata_d = ex.result[DATA_W-1:0];
          end
          if (writes_flags(ex.opcode)) begin
            flags_d[FLAG_Z] = ex.zero_in;
            flags_d[FLAG_C] = ex.carry_in;
            flags_d[FLAG_A] = ex.ac_in;
            flags_d[FLAG_P] = ex.parity_in;
          end
          if (ex.opcode == OP_CMP) cmp_d = ex.result[0];
          if (ex.opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end
        end
      end
      StWriteHi: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = hi_addr_q;
        rf_wdata_d = hi_data_q;
        state_d    = StAccept;
      end
      StHalted: ;
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAccept;
      rf_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      hi_addr_q  <= '0;
      hi_data_q  <= '0;
      flags_r    <= '0;
      cmp_r      <= 1'b0;
      halted_r   <= 1'b0;
      retire_r   <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      dm_we_q    <= dm_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      hi_addr_q  <= hi_addr_d;
      hi_data_q  <= hi_data_d;
      flags_r    <= flags_d;
      cmp_r      <= cmp_d;
      halted_r   <= halted_d;
      retire_r   <= retire_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign flags_q    = flags_r;
  assign cmp_q      = cmp_r;
  assign halted     = halted_r;
  assign retire_cnt = retire_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: drives one instruction per step and checks the
// registered commit outputs against hand-computed values.
module tb_writeback_stage;
  import core_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                rf_we, dm_we, cmp_q, halted;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata, dm_wdata;
  logic [MEM_AW-1:0]   dm_addr;
  logic [3:0]          flags_q;
  logic [15:0]         retire_cnt;
  int                  tests = 0;
  int                  fails = 0;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk        (clk),
    .reset      (reset),
    .ex         (bus.slave),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .flags_q    (flags_q),
    .cmp_q      (cmp_q),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [OPC_W-1:0] op, input logic [REG_AW-1:0] d,
                       input logic [MEM_AW-1:0] ma, input logic [15:0] res,
                       input logic [3:0] f);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.rd        = d;
    bus.mem_addr  = ma;
    bus.result    = res;
    bus.zero_in   = f[3];
    bus.carry_in  = f[2];
    bus.ac_in     = f[1];
    bus.parity_in = f[0];
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    drive(OP_MOV, 3'd0, 4'd0, 16'h0, 4'h0);
    bus.in_valid = 1'b0;
    step();
    step();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready_rel", 32'(bus.in_ready), 32'd1);

    // ADD rd=3
    drive(OP_ADD, 3'd3, 4'd0, 16'h0042, 4'b0100);
    step();
    bus.in_valid = 1'b0;
    chk("add_we", 32'(rf_we), 32'd1);
    chk("add_waddr", 32'(rf_waddr), 32'd3);
    chk("add_wdata", 32'(rf_wdata), 32'h42);
    chk("add_flags", 32'(flags_q), 32'b0100);
    chk("add_retire", 32'(retire_cnt), 32'd1);
    chk("add_dm_we", 32'(dm_we), 32'd0);
    step();
    chk("idle_we", 32'(rf_we), 32'd0);

    // MUL rd=7: low byte to r7, then high byte wraps to r0
    drive(OP_MUL, 3'd7, 4'd0, 16'h1234, 4'b1010);
    step();
    bus.in_valid = 1'b0;
    chk("mul_lo_we", 32'(rf_we), 32'd1);
    chk("mul_lo_addr", 32'(rf_waddr), 32'd7);
    chk("mul_lo_data", 32'(rf_wdata), 32'h34);
    chk("mul_ready0", 32'(bus.in_ready), 32'd0);
    chk("mul_flags", 32'(flags_q), 32'b1010);
    step();
    chk("mul_hi_we", 32'(rf_we), 32'd1);
    chk("mul_hi_addr", 32'(rf_waddr), 32'd0);
    chk("mul_hi_data", 32'(rf_wdata), 32'h12);
    chk("mul_ready1", 32'(bus.in_ready), 32'd1);
    chk("mul_retire", 32'(retire_cnt), 32'd2);

    // STORE then LOAD back-to-back; flags must not move
    drive(OP_STORE, 3'd5, 4'hA, 16'h00FF, 4'b1111);
    step();
    chk("st_dm_we", 32'(dm_we), 32'd1);
    chk("st_dm_addr", 32'(dm_addr), 32'hA);
    chk("st_dm_data", 32'(dm_wdata), 32'hFF);
    chk("st_rf_we", 32'(rf_we), 32'd0);
    chk("st_flags", 32'(flags_q), 32'b1010);
    drive(OP_LOAD, 3'd2, 4'h3, 16'h0077, 4'b0101);
    step();
    bus.in_valid = 1'b0;
    chk("ld_dm_we", 32'(dm_we), 32'd0);
    chk("ld_rf_we", 32'(rf_we), 32'd1);
    chk("ld_addr", 32'(rf_waddr), 32'd2);
    chk("ld_data", 32'(rf_wdata), 32'h77);
    chk("ld_flags", 32'(flags_q), 32'b1010);
    chk("ld_retire", 32'(retire_cnt), 32'd4);

    // CMP then branch
    drive(OP_CMP, 3'd4, 4'd0, 16'h0001, 4'b0001);
    step();
    chk("cmp_q", 32'(cmp_q), 32'd1);
    chk("cmp_flags", 32'(flags_q), 32'b0001);
    chk("cmp_rf_we", 32'(rf_we), 32'd0);
    drive(OP_BR1, 3'd4, 4'd0, 16'h0000, 4'b1111);
    step();
    bus.in_valid = 1'b0;
    chk("br_cmp", 32'(cmp_q), 32'd1);
    chk("br_flags", 32'(flags_q), 32'b0001);
    chk("br_writes", 32'({rf_we, dm_we}), 32'd0);
    chk("br_retire", 32'(retire_cnt), 32'd6);

    // Unlisted opcode behaves as NOP
    drive(5'b11010, 3'd1, 4'd1, 16'h00AA, 4'b1111);
    step();
    bus.in_valid = 1'b0;
    chk("nop_writes", 32'({rf_we, dm_we}), 32'd0);
    chk("nop_flags", 32'(flags_q), 32'b0001);
    chk("nop_retire", 32'(retire_cnt), 32'd7);

    // HALT, then ADD held valid must be ignored
    drive(OP_HALT, 3'd0, 4'd0, 16'h0, 4'b0000);
    step();
    chk("halt_q", 32'(halted), 32'd1);
    chk("halt_ready", 32'(bus.in_ready), 32'd0);
    chk("halt_retire", 32'(retire_cnt), 32'd8);
    drive(OP_ADD, 3'd6, 4'd0, 16'h0099, 4'b1111);
    step();
    step();
    step();
    chk("halt_no_we", 32'(rf_we), 32'd0);
    chk("halt_no_retire", 32'(retire_cnt), 32'd8);
    chk("halt_flags", 32'(flags_q), 32'b0001);
    chk("halt_ready2", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_retire", 32'(retire_cnt), 32'd0);
    chk("hrst_flags_cmp", 32'({flags_q, cmp_q}), 32'd0);
    reset = 1'b0;
    #1;

    // DIV rd=1, reset during the high-byte cycle
    drive(OP_DIV, 3'd1, 4'd0, 16'h0503, 4'b0110);
    step();
    bus.in_valid = 1'b0;
    chk("div_lo_we", 32'(rf_we), 32'd1);
    chk("div_lo_data", 32'(rf_wdata), 32'h03);
    chk("div_ready0", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    step();
    chk("drst_rf_we", 32'(rf_we), 32'd0);
    chk("drst_addr_data", 32'({rf_waddr, rf_wdata, dm_addr, dm_wdata}), 32'd0);
    chk("drst_retire", 32'(retire_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("drst_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("drst_no_hi", 32'(rf_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
